// File: rtl/riscv_retire_trace_if.sv
// riscv_retire_trace_if: the trace drain port of the retirement monitor.
//   master (monitor): drives trace_valid_o and the head record fields, samples trace_ready_i
//   slave  (consumer): samples the head record, drives trace_ready_i
// A record is consumed on any cycle with trace_valid_o && trace_ready_i.
interface riscv_retire_trace_if;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_opcode_o;
  logic [31:0] trace_result_o;
  logic [4:0]  trace_rd_o;
  logic        trace_pipe_o;

  modport master (
    output trace_valid_o, trace_pc_o, trace_opcode_o, trace_result_o, trace_rd_o, trace_pipe_o,
    input  trace_ready_i
  );

  modport slave (
    input  trace_valid_o, trace_pc_o, trace_opcode_o, trace_result_o, trace_rd_o, trace_pipe_o,
    output trace_ready_i
  );
endinterface

// File: rtl/riscv_retire_trace.sv
// riscv_retire_trace: retirement monitor behind the dual-issue writeback stage.
//   clk_i, rst_i        clock, synchronous active-high reset
//   pipe0_* / pipe1_*   retire records; pipe1 is younger than pipe0 in the same cycle
//   trace               first-word-fall-through drain of buffered records (master modport)
//   cycle_count_o       cycles since reset, frozen at halt
//   instr_count_o       retired instructions since reset, frozen at halt
//   drop_count_o        records lost to a full FIFO, saturating
//   halt_o              sticky, rises HALT_DELAY cycles after a CSRRW retires
// Optional build macro RETIRE_TRACE_FILTER_EN: records with rd==0 are counted
// and can trigger halt, but are never buffered (and never count as drops).
module riscv_retire_trace #(
  parameter int DEPTH      = 16,
  parameter int HALT_DELAY = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        pipe0_valid_i,
  input  logic [31:0]                 pipe0_pc_i,
  input  logic [31:0]                 pipe0_opcode_i,
  input  logic [4:0]                  pipe0_rd_i,
  input  logic [31:0]                 pipe0_result_i,
  input  logic                        pipe1_valid_i,
  input  logic [31:0]                 pipe1_pc_i,
  input  logic [31:0]                 pipe1_opcode_i,
  input  logic [4:0]                  pipe1_rd_i,
  input  logic [31:0]                 pipe1_result_i,
  riscv_retire_trace_if.master        trace,
  output logic [31:0]                 cycle_count_o,
  output logic [31:0]                 instr_count_o,
  output logic [15:0]                 drop_count_o,
  output logic                        halt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opcode;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        pipe;
  } rec_t;

  typedef enum logic [1:0] {RUN, DELAY, HALTED} state_e;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q, cycle_d, instr_q, instr_d;
  logic [15:0]   drop_q, drop_d;
  state_e        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic          halt_q, halt_d;

  logic          active, want0, want1, do0, do1, det, pop;
  logic [CW-1:0] free;
  logic [1:0]    npush, ndrop;
  logic [16:0]   drop_sum;
  rec_t          rec0, rec1, head;

  always_comb begin
    active = (state_q != HALTED);
`ifdef RETIRE_TRACE_FILTER_EN
    want0 = active && pipe0_valid_i && (pipe0_rd_i != 5'd0);
    want1 = active && pipe1_valid_i && (pipe1_rd_i != 5'd0);
`else
    want0 = active && pipe0_valid_i;
    want1 = active && pipe1_valid_i;
`endif
    // Space is judged on the start-of-cycle count; a same-cycle pop does not help.
    free  = CW'(DEPTH) - count_q;
    do0   = want0 && (free != '0);
    do1   = want1 && ((free >= CW'(2)) || ((free == CW'(1)) && !do0));
    npush = {1'b0, do0} + {1'b0, do1};
    ndrop = {1'b0, want0 && !do0} + {1'b0, want1 && !do1};
    pop   = (count_q != '0) && trace.trace_ready_i;

    rec0 = '{pc: pipe0_pc_i, opcode: pipe0_opcode_i, rd: pipe0_rd_i, result: pipe0_result_i, pipe: 1'b0};
    rec1 = '{pc: pipe1_pc_i, opcode: pipe1_opcode_i, rd: pipe1_rd_i, result: pipe1_result_i, pipe: 1'b1};

    mem_d = mem_q;
    if (do0) mem_d[wr_ptr_q] = rec0;
    if (do1) mem_d[wr_ptr_q + AW'(do0)] = rec1;

    wr_ptr_d = wr_ptr_q + AW'(npush);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(npush) - CW'(pop);

    drop_sum = {1'b0, drop_q} + 17'(ndrop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    cycle_d = cycle_q;
    instr_d = instr_q;
    if (active) begin
      cycle_d = cycle_q + 32'd1;
      instr_d = instr_q + 32'(pipe0_valid_i) + 32'(pipe1_valid_i);
    end

    // CSRRW: SYSTEM major opcode with funct3 = 001.
    det = (pipe0_valid_i && pipe0_opcode_i[6:0] == 7'b1110011 && pipe0_opcode_i[14:12] == 3'b001) ||
          (pipe1_valid_i && pipe1_opcode_i[6:0] == 7'b1110011 && pipe1_opcode_i[14:12] == 3'b001);

    state_d = state_q;
    timer_d = timer_q;
    halt_d  = halt_q;
    case (state_q)
      RUN: if (det) begin
        state_d = DELAY;
        timer_d = 8'(HALT_DELAY - 1);
      end
      DELAY: if (timer_q == 8'd0) begin
        state_d = HALTED;
        halt_d  = 1'b1;
      end else begin
        timer_d = timer_q - 8'd1;
      end
      HALTED: halt_d = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
      drop_q   <= '0;
      state_q  <= RUN;
      timer_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      halt_q   <= halt_d;
    end
  end

  // Storage needs no reset: nothing is read unless count_q says it was written.
  always_ff @(posedge clk_i) mem_q <= mem_d;

  // Head fields are forced to zero when empty so stale entries never leak out.
  always_comb begin
    head                 = mem_q[rd_ptr_q];
    trace.trace_valid_o  = (count_q != '0);
    trace.trace_pc_o     = trace.trace_valid_o ? head.pc     : 32'd0;
    trace.trace_opcode_o = trace.trace_valid_o ? head.opcode : 32'd0;
    trace.trace_result_o = trace.trace_valid_o ? head.result : 32'd0;
    trace.trace_rd_o     = trace.trace_valid_o ? head.rd     : 5'd0;
    trace.trace_pipe_o   = trace.trace_valid_o && head.pipe;
  end

  assign cycle_count_o = cycle_q;
  assign instr_count_o = instr_q;
  assign drop_count_o  = drop_q;
  assign halt_o        = halt_q;
endmodule

// File: tb/tb_riscv_retire_trace.sv
module tb_riscv_retire_trace;
  localparam int DEPTH      = 16;
  localparam int HALT_DELAY = 10;
  localparam logic [31:0] CSRRW_OP = 32'h34029073;
  localparam logic [31:0] ALU_OP   = 32'h00A00033;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        p0_v, p1_v;
  logic [31:0] p0_pc, p0_op, p0_res, p1_pc, p1_op, p1_res;
  logic [4:0]  p0_rd, p1_rd;
  logic [31:0] cycle_count, instr_count;
  logic [15:0] drop_count;
  logic        halt;

  riscv_retire_trace_if tif();

  riscv_retire_trace #(.DEPTH(DEPTH), .HALT_DELAY(HALT_DELAY)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pipe0_valid_i(p0_v), .pipe0_pc_i(p0_pc), .pipe0_opcode_i(p0_op), .pipe0_rd_i(p0_rd), .pipe0_result_i(p0_res),
    .pipe1_valid_i(p1_v), .pipe1_pc_i(p1_pc), .pipe1_opcode_i(p1_op), .pipe1_rd_i(p1_rd), .pipe1_result_i(p1_res),
    .trace(tif.master),
    .cycle_count_o(cycle_count), .instr_count_o(instr_count), .drop_count_o(drop_count), .halt_o(halt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of records + edge arithmetic ----------------
  typedef struct {
    logic [31:0] pc, op, res;
    logic [4:0]  rd;
    logic        pipe;
  } trec_t;

  trec_t       mq[$];
  int unsigned m_cyc, m_instr;
  int          m_drop, m_e, m_halt_e;
  bit          m_det;

  function automatic bit is_csrrw(input logic v, input logic [31:0] op);
    return v && (op[6:0] == 7'b1110011) && (op[14:12] == 3'b001);
  endfunction

  function automatic bit keep(input logic [4:0] rd);
`ifdef RETIRE_TRACE_FILTER_EN
    return rd != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cyc = 0; m_instr = 0; m_drop = 0; m_e = 0; m_halt_e = 0; m_det = 0;
  endtask

  // Halt is just "edge index past detection edge + HALT_DELAY"; edges up to and
  // including that one still count and push.
  task automatic model_edge();
    trec_t w[$];
    int    free;
    bit    act;
    m_e++;
    act  = !m_det || (m_e <= m_halt_e);
    free = DEPTH - mq.size();
    if (mq.size() != 0 && tif.trace_ready_i) void'(mq.pop_front());
    if (act) begin
      m_cyc++;
      m_instr += 32'(p0_v) + 32'(p1_v);
      if (!m_det && (is_csrrw(p0_v, p0_op) || is_csrrw(p1_v, p1_op))) begin
        m_det    = 1;
        m_halt_e = m_e + HALT_DELAY;
      end
      if (p0_v && keep(p0_rd)) w.push_back('{pc: p0_pc, op: p0_op, res: p0_res, rd: p0_rd, pipe: 1'b0});
      if (p1_v && keep(p1_rd)) w.push_back('{pc: p1_pc, op: p1_op, res: p1_res, rd: p1_rd, pipe: 1'b1});
      foreach (w[i]) begin
        if (free > 0) begin mq.push_back(w[i]); free--; end
        else if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic model_cmp();
    chk("valid", 32'(tif.trace_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("pc", tif.trace_pc_o, mq[0].pc);
      chk("opcode", tif.trace_opcode_o, mq[0].op);
      chk("result", tif.trace_result_o, mq[0].res);
      chk("rd", 32'(tif.trace_rd_o), 32'(mq[0].rd));
      chk("pipe", 32'(tif.trace_pipe_o), 32'(mq[0].pipe));
    end
    chk("cycle_count", cycle_count, m_cyc);
    chk("instr_count", instr_count, m_instr);
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("halt", 32'(halt), 32'(m_det && (m_e >= m_halt_e)));
  endtask

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic set_in(input logic v0, input logic [31:0] pc0, input logic [31:0] op0, input logic [4:0] rd0,
                        input logic [31:0] res0, input logic v1, input logic [31:0] pc1, input logic [31:0] op1,
                        input logic [4:0] rd1, input logic [31:0] res1, input logic rdy);
    p0_v = v0; p0_pc = pc0; p0_op = op0; p0_rd = rd0; p0_res = res0;
    p1_v = v1; p1_pc = pc1; p1_op = op1; p1_rd = rd1; p1_res = res1;
    tif.trace_ready_i = rdy;
  endtask

  task automatic idle(input logic rdy);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic dual(input logic [31:0] pc, input logic rdy);
    set_in(1, pc, ALU_OP, 5'd3, pc ^ 32'h5A5A0000, 1, pc + 4, ALU_OP, 5'd4, pc ^ 32'h0000A5A5, rdy);
  endtask

  task automatic single(input logic [31:0] pc, input logic rdy);
    set_in(1, pc, ALU_OP, 5'd3, pc ^ 32'h5A5A0000, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst valid", 32'(tif.trace_valid_o), 0);
    chk("rst pc", tif.trace_pc_o, 0);
    chk("rst cycle", cycle_count, 0);
    chk("rst instr", instr_count, 0);
    chk("rst drop", 32'(drop_count), 0);
    chk("rst halt", 32'(halt), 0);
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] pc0;
    logic [4:0]  rd0;
    logic        v1;
    logic [31:0] pc1;
    logic [4:0]  rd1;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic        e_pipe;
    logic [31:0] e_instr;
    logic [31:0] e_cycle;
  } vec_t;

  initial begin
    vec_t        vt[5];
    logic [31:0] r0, r1;
    int          n;

    // ---- directed table: single then dual retire ----
    vt[0] = '{0, 32'h0,        5'd0, 0, 32'h0,        5'd0, 1, 0, 32'h0,        5'd0, 0, 32'd0, 32'd1};
    vt[1] = '{1, 32'h80000000, 5'd5, 0, 32'h0,        5'd0, 1, 1, 32'h80000000, 5'd5, 0, 32'd1, 32'd2};
    vt[2] = '{1, 32'h80000004, 5'd6, 1, 32'h80000008, 5'd7, 1, 1, 32'h80000004, 5'd6, 0, 32'd3, 32'd3};
    vt[3] = '{0, 32'h0,        5'd0, 0, 32'h0,        5'd0, 1, 1, 32'h80000008, 5'd7, 1, 32'd3, 32'd4};
    vt[4] = '{0, 32'h0,        5'd0, 0, 32'h0,        5'd0, 1, 0, 32'h0,        5'd0, 0, 32'd3, 32'd5};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(vt[i].v0, vt[i].pc0, ALU_OP, vt[i].rd0, 32'h2A, vt[i].v1, vt[i].pc1, ALU_OP, vt[i].rd1, 32'h2B, vt[i].rdy);
      step();
      chk($sformatf("tbl%0d valid", i), 32'(tif.trace_valid_o), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("tbl%0d pc", i), tif.trace_pc_o, vt[i].e_pc);
        chk($sformatf("tbl%0d rd", i), 32'(tif.trace_rd_o), 32'(vt[i].e_rd));
        chk($sformatf("tbl%0d pipe", i), 32'(tif.trace_pipe_o), 32'(vt[i].e_pipe));
      end
      chk($sformatf("tbl%0d instr", i), instr_count, vt[i].e_instr);
      chk($sformatf("tbl%0d cycle", i), cycle_count, vt[i].e_cycle);
    end

    // ---- overflow: 9 dual retires with ready low, then drain ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dual(32'h1000 + 32'(8 * i), 1'b0);
      step();
      chk("fill head stable", tif.trace_pc_o, 32'h1000);
    end
    chk("fill drops", 32'(drop_count), 2);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", tif.trace_pc_o, 32'h1000 + 32'(4 * i));
      idle(1'b1);
      step();
    end
    chk("drain empty", 32'(tif.trace_valid_o), 0);

    // ---- 15 held, dual retire with simultaneous pop ----
    do_reset();
    for (int i = 0; i < 7; i++) begin dual(32'h2000 + 32'(8 * i), 1'b0); step(); end
    single(32'h2038, 1'b0); step();
    dual(32'h3000, 1'b1); step();
    chk("pop+dual drop", 32'(drop_count), 1);
    n = 0;
    idle(1'b1);
    while (tif.trace_valid_o && n < 40) begin step(); n++; end
    chk("15 left after pop", n, 15);

`ifdef RETIRE_TRACE_FILTER_EN
    // ---- filtered pipe0 leaves its slot for pipe1 ----
    do_reset();
    for (int i = 0; i < 7; i++) begin dual(32'h4000 + 32'(8 * i), 1'b0); step(); end
    single(32'h4038, 1'b0); step();
    set_in(1, 32'h5000, ALU_OP, 5'd0, 32'h1, 1, 32'h5004, ALU_OP, 5'd7, 32'h2, 1'b0); step();
    chk("filt drop", 32'(drop_count), 0);
    chk("filt instr", instr_count, 32'd17);
    idle(1'b1);
    n = 0;
    while (tif.trace_valid_o && n < 40) begin
      if (n == 15) chk("filt last pc", tif.trace_pc_o, 32'h5004);
      step(); n++;
    end
    chk("filt stored", n, 16);
`endif

    // ---- randomized against the model ----
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0 = $urandom; r1 = $urandom;
      r0[6:0] = 7'h33; r1[6:0] = 7'h13;
      set_in(1'($urandom_range(0, 1)), $urandom, r0, 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 1)), $urandom, r1, 5'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 3) != 0 || i > 380));
      if (i % 100 < 30) tif.trace_ready_i = 1'b0;
      step();
    end

    // ---- halt: CSRRW on edge 4, halt after edge 14 ----
    do_reset();
    for (int i = 0; i < 3; i++) begin single(32'h6000 + 32'(4 * i), 1'b0); step(); end
    set_in(1, 32'h600C, CSRRW_OP, 5'd0, 32'h0, 1, 32'h6010, ALU_OP, 5'd9, 32'h9, 1'b0);
    step();
    for (int k = 1; k <= 14; k++) begin
      r0 = $urandom; r0[6:0] = 7'h33;
      set_in(1, 32'h7000 + 32'(8 * k), r0, 5'd2, $urandom, 1, 32'h7004 + 32'(8 * k), CSRRW_OP, 5'd3, 0,
             1'($urandom_range(0, 1)));
      step();
      chk($sformatf("halt k=%0d", k), 32'(halt), 32'(k >= HALT_DELAY));
    end
    chk("frozen cycle", cycle_count, 32'd14);
    n = 0;
    idle(1'b1);
    while (tif.trace_valid_o && n < 40) begin step(); n++; end
    chk("halt drain empty", 32'(tif.trace_valid_o), 0);
    chk("halt sticky", 32'(halt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
